// File: rtl/fwd_pipe_reg.sv
// Pipeline operand register with priority forwarding from NSRC younger stages.
// Re-checks forwarding sources against the held register while stalled.
module fwd_pipe_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3,
    parameter int unsigned REGW  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [REGW-1:0]         in_reg,
    input  logic                    in_valid,
    input  logic [NSRC-1:0]         src_we,
    input  logic [NSRC*REGW-1:0]    src_addr,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    output logic [WIDTH-1:0]        out_data,
    output logic [REGW-1:0]         out_reg,
    output logic                    out_valid,
    output logic                    out_hit,
    output logic [7:0]              stall_cnt
);

    localparam int unsigned CNTW    = 8;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [REGW-1:0]  lookup_reg_c;
    logic             hit_c;
    logic [WIDTH-1:0] fwd_data_c;

    // Lowest-index matching source wins; register 0 is never forwarded.
    always_comb begin
        lookup_reg_c = en ? in_reg : out_reg;
        hit_c        = 1'b0;
        fwd_data_c   = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (!hit_c && src_we[i] &&
                src_addr[i*int'(REGW) +: REGW] == lookup_reg_c &&
                lookup_reg_c != '0) begin
                hit_c      = 1'b1;
                fwd_data_c = src_data[i*int'(WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            out_data  <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            stall_cnt <= '0;
        end else if (en) begin
            out_data  <= hit_c ? fwd_data_c : in_data;
            out_reg   <= in_reg;
            out_valid <= in_valid;
            out_hit   <= hit_c;
            stall_cnt <= '0;
        end else begin
            // Late-arriving producer updates the held operand in place.
            if (hit_c) begin
                out_data <= fwd_data_c;
                out_hit  <= 1'b1;
            end
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_pipe_reg.sv
// Self-checking bench for fwd_pipe_reg: directed scenarios plus randomized
// traffic checked every cycle against a behavioural model.
module tb_fwd_pipe_reg;

    localparam int W = 32;
    localparam int N = 3;
    localparam int R = 5;

    logic           clk = 1'b0;
    logic           reset, en, flush, in_valid;
    logic [W-1:0]   in_data;
    logic [R-1:0]   in_reg;
    logic [N-1:0]   src_we;
    logic [N*R-1:0] src_addr;
    logic [N*W-1:0] src_data;
    logic [W-1:0]   out_data;
    logic [R-1:0]   out_reg;
    logic           out_valid, out_hit;
    logic [7:0]     stall_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [W-1:0] m_data  = '0;
    logic [R-1:0] m_reg   = '0;
    logic         m_valid = 1'b0;
    logic         m_hit   = 1'b0;
    int           m_cnt   = 0;

    fwd_pipe_reg #(.WIDTH(W), .NSRC(N), .REGW(R)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_data(in_data), .in_reg(in_reg), .in_valid(in_valid),
        .src_we(src_we), .src_addr(src_addr), .src_data(src_data),
        .out_data(out_data), .out_reg(out_reg), .out_valid(out_valid),
        .out_hit(out_hit), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect all matching sources, take the youngest (lowest index).
    always @(posedge clk) begin : model
        logic [R-1:0] lk;
        int           hits[$];
        logic [W-1:0] fd;
        lk = en ? in_reg : m_reg;
        hits.delete();
        if (lk != 0)
            for (int i = 0; i < N; i++)
                if (src_we[i] && src_addr[i*R +: R] == lk) hits.push_back(i);
        fd = (hits.size() > 0) ? src_data[hits[0]*W +: W] : '0;
        if (!reset || flush) begin
            m_data = '0; m_reg = '0; m_valid = 1'b0; m_hit = 1'b0; m_cnt = 0;
        end else if (en) begin
            m_data  = (hits.size() > 0) ? fd : in_data;
            m_reg   = in_reg;
            m_valid = in_valid;
            m_hit   = hits.size() > 0;
            m_cnt   = 0;
        end else begin
            if (hits.size() > 0) begin
                m_data = fd;
                m_hit  = 1'b1;
            end
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_data",  64'(out_data),  64'(m_data));
            chk("cyc_reg",   64'(out_reg),   64'(m_reg));
            chk("cyc_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc_hit",   64'(out_hit),   64'(m_hit));
            chk("cyc_cnt",   64'(stall_cnt), 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_reg = '0; src_we = '0; src_addr = '0; src_data = '0;
    endtask

    task automatic set_src(input int i, input logic we, input logic [R-1:0] a,
                           input logic [W-1:0] d);
        src_we[i]          = we;
        src_addr[i*R +: R] = a;
        src_data[i*W +: W] = d;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        in_data = 32'hDEAD; in_reg = 5'd7; in_valid = 1'b1; flush = 1'b0;
        step();
        chk_en = 1'b1;
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_cnt", 64'(stall_cnt), 64'h0);

        // Two matching sources: youngest wins.
        idle();
        in_reg = 5'd8; in_data = 32'h11; in_valid = 1'b1;
        set_src(0, 1'b1, 5'd8, 32'hAA);
        set_src(1, 1'b1, 5'd8, 32'hBB);
        set_src(2, 1'b0, 5'd3, 32'hCC);
        step();
        chk("prio_data", 64'(out_data), 64'hAA);
        chk("prio_hit", 64'(out_hit), 64'h1);

        // Register 0 never forwarded.
        idle();
        in_reg = 5'd0; in_data = 32'h5;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'd0, 32'h99 + 32'(i));
        step();
        chk("r0_data", 64'(out_data), 64'h5);
        chk("r0_hit", 64'(out_hit), 64'h0);

        // Load then stall with a late forward.
        idle();
        in_reg = 5'd9; in_data = 32'h1; in_valid = 1'b1;
        step();
        chk("ld_data", 64'(out_data), 64'h1);
        chk("ld_hit", 64'(out_hit), 64'h0);
        en = 1'b0;
        step();
        chk("st1_data", 64'(out_data), 64'h1);
        set_src(2, 1'b1, 5'd9, 32'h77);
        step();
        chk("st2_data", 64'(out_data), 64'h77);
        chk("st2_hit", 64'(out_hit), 64'h1);
        set_src(2, 1'b0, 5'd9, 32'h0);
        step();
        chk("st3_data", 64'(out_data), 64'h77);
        chk("st3_hit", 64'(out_hit), 64'h1);
        chk("st3_cnt", 64'(stall_cnt), 64'd3);
        chk("st3_valid", 64'(out_valid), 64'h1);

        // Saturation.
        repeat (297) step();
        chk("sat_cnt", 64'(stall_cnt), 64'd255);
        en = 1'b1;
        step();
        chk("sat_clr", 64'(stall_cnt), 64'd0);

        // Flush with en=0 and en=1.
        idle(); in_reg = 5'd4; in_data = 32'h44; in_valid = 1'b1;
        step();
        en = 1'b0; step();
        flush = 1'b1; step();
        chk("fl0_data", 64'(out_data), 64'h0);
        chk("fl0_valid", 64'(out_valid), 64'h0);
        chk("fl0_cnt", 64'(stall_cnt), 64'h0);
        flush = 1'b0; en = 1'b1; step();
        flush = 1'b1; step();
        chk("fl1_data", 64'(out_data), 64'h0);
        chk("fl1_reg", 64'(out_reg), 64'h0);

        // Reset mid-stall, then normal load.
        idle(); in_reg = 5'd6; in_data = 32'h66; in_valid = 1'b1;
        step();
        en = 1'b0; step(); step();
        reset = 1'b0; step();
        chk("rms_valid", 64'(out_valid), 64'h0);
        chk("rms_cnt", 64'(stall_cnt), 64'h0);
        chk("rms_data", 64'(out_data), 64'h0);
        reset = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 32'h3; in_reg = 5'd2;
        step();
        chk("rel_valid", 64'(out_valid), 64'h1);
        chk("rel_data", 64'(out_data), 64'h3);

        // Reset glitch between edges has no effect.
        en = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        step();
        chk("glitch_valid", 64'(out_valid), 64'h1);
        chk("glitch_cnt", 64'(stall_cnt), 64'd1);

        // Randomized traffic; small register space to make matches frequent.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 99) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            en       = ($urandom_range(0, 2) != 0);
            in_valid = 1'($urandom);
            in_reg   = R'($urandom_range(0, 7));
            in_data  = $urandom;
            for (int i = 0; i < N; i++)
                set_src(i, 1'($urandom), R'($urandom_range(0, 7)), $urandom);
            step();
        end

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_pipe_reg.md
FWD_PIPE_REG -- requirements
Module: fwd_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter NSRC, default 3, meaning the number of forwarding sources (index 0 = youngest/nearest stage).
REQ-003 The block SHALL have parameter REGW, default 5, meaning the register-number width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port en, input, 1, advance enable (0 = stall/hold).
REQ-008 The block SHALL have port flush, input, 1, which inserts a bubble.
REQ-009 The block SHALL have port in_data, input, WIDTH, the operand read in the previous stage.
REQ-010 The block SHALL have port in_reg, input, REGW, the register number of in_data.
REQ-011 The block SHALL have port in_valid, input, 1, marking the incoming instruction as real.
REQ-012 The block SHALL have port src_we, input, NSRC, the per-source write-enable.
REQ-013 The block SHALL have port src_addr, input, NSRC*REGW, the per-source destination register (source i at bits [i*REGW +: REGW]).
REQ-014 The block SHALL have port src_data, input, NSRC*WIDTH, the per-source result (source i at bits [i*WIDTH +: WIDTH]).
REQ-015 The block SHALL have port out_data, output, WIDTH, the registered forwarded operand.
REQ-016 The block SHALL have port out_reg, output, REGW, the registered register number.
REQ-017 The block SHALL have port out_valid, output, 1, the registered valid.
REQ-018 The block SHALL have port out_hit, output, 1, set when out_data was last written from a forwarding source.
REQ-019 The block SHALL have port stall_cnt, output, 8, counting consecutive held cycles.

Function
REQ-020 Match: source i SHALL match register r when src_we[i]=1, src_addr[i]==r and r!=0.
REQ-021 Priority: on multiple matches, the lowest index SHALL win; no match selects the non-forwarded value.
REQ-022 Advance (reset=1, flush=0, en=1): on the clock edge out_reg<=in_reg, out_valid<=in_valid, out_data<=winning src_data matched against in_reg, else in_data; out_hit<=match found; stall_cnt<=0.
REQ-023 Hold (reset=1, flush=0, en=0): out_reg and out_valid SHALL hold; sources SHALL be matched against out_reg; on a match out_data<=winning src_data and out_hit<=1, else out_data and out_hit hold.
REQ-024 During hold, stall_cnt SHALL increment by 1 per cycle, saturating at 255.
REQ-025 Flush (reset=1, flush=1): out_data, out_reg, out_valid, out_hit and stall_cnt SHALL all clear to 0 on the edge, regardless of en.
REQ-026 Latency: exactly one cycle from inputs to outputs; there SHALL be no combinational path from any input to any output.
REQ-027 Register 0 SHALL never be forwarded; out_data then equals in_data (advance) or holds (stall), even if a source writes address 0.
REQ-028 in_valid=0 SHALL NOT suppress forwarding; data is still captured with out_valid=0.
REQ-029 NSRC=1 and WIDTH values 1..64 SHALL be legal; no other behaviour depends on WIDTH.

Reset
REQ-030 When reset=0 at a rising edge, out_data, out_reg, out_valid, out_hit and stall_cnt SHALL all become 0, overriding flush and en.
REQ-031 A reset asserted mid-stall SHALL clear stall_cnt and discard the held operand; the first edge with reset=1, en=1 SHALL load normally.
REQ-032 Reset SHALL be sampled only on clk rising edges; an assertion between edges SHALL have no effect.

Verification
REQ-033 Scenario: in_reg=8, in_data=0x11, src_we=3'b011, src_addr={x,8,8}, src_data[0]=0xAA, src_data[1]=0xBB, en=1 -> out_data=0xAA, out_hit=1.
REQ-034 Scenario: in_reg=0, in_data=0x5, src_we=3'b111, all src_addr=0 -> out_data=0x5, out_hit=0.
REQ-035 Scenario: load reg 9 with data 0x1 (no hit), then en=0 for 3 cycles with src 2 writing reg 9 = 0x77 on the 2nd cycle -> out_data=0x77 from that edge, out_hit=1, stall_cnt=3 after the 3rd cycle.
REQ-036 Scenario: en=0 held for 300 cycles -> stall_cnt saturates at 255; first en=1 edge -> 0.
REQ-037 Scenario: flush=1 with en=0, and separately with en=1 -> all outputs 0 on the next edge.
REQ-038 Scenario: reset=0 pulsed mid-stall with out_valid=1 -> all outputs 0 on that edge; reset=1 with in_valid=1, in_data=0x3 -> out_valid=1, out_data=0x3.
